// File: rtl/parking_pkg.sv
// ============================================================================
// Package  : parking_pkg
// Brief    : Shared types and constants for the parking gate arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

  // Width of the occupancy / spaces_left counters (capacity up to 15)
  localparam int OCC_W            = 4;
  localparam int CAPACITY_DEFAULT = 5;

  // Gate controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPENING = 2'd1,
    ST_PASS    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  // Larger of two integers, used to size the shared phase timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : parking_pkg

`default_nettype wire

// File: rtl/parking_gate_arbiter_if.sv
// ============================================================================
// Interface : parking_gate_arbiter_if
// Brief     : Loop sensors, beam sensor, grants, gate command and lot status.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parking_gate_arbiter_if;
  import parking_pkg::*;

  logic             entry_req;
  logic             exit_req;
  logic             car_passed;
  logic             entry_grant;
  logic             exit_grant;
  logic             gate_open;
  logic             entry_deny;
  logic             timeout_err;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] spaces_left;
  logic             parking_full;

  // Sensor side: drives requests and the beam pulse, observes the gate
  modport master (
    output entry_req, exit_req, car_passed,
    input  entry_grant, exit_grant, gate_open, entry_deny, timeout_err,
    input  occupancy, spaces_left, parking_full
  );

  // Arbiter side
  modport slave (
    input  entry_req, exit_req, car_passed,
    output entry_grant, exit_grant, gate_open, entry_deny, timeout_err,
    output occupancy, spaces_left, parking_full
  );

endinterface : parking_gate_arbiter_if

`default_nettype wire

// File: rtl/parking_timer.sv
// ============================================================================
// Module   : parking_timer
// Brief    : Loadable down-counter; done is high while the count is zero.
//            Loading N-1 makes a phase last exactly N clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_timer #(
  parameter int WIDTH = 8
) (
  input  wire             clk,
  input  wire             reset,
  input  wire             load,
  input  wire [WIDTH-1:0] load_value,
  output logic            done
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule : parking_timer

`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// Module   : parking_gate_arbiter
// Brief    : Single-barrier entry/exit arbiter with round-robin between
//            directions, occupancy tracking, full-lot denial and pass timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = CAPACITY_DEFAULT,
  parameter int MOVE_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 32
) (
  input  wire                   clk,
  input  wire                   reset,
  parking_gate_arbiter_if.slave gate
);

  localparam int               c_tmr_w     = $clog2(max_int(MOVE_CYCLES, PASS_TIMEOUT) + 1);
  localparam logic [OCC_W-1:0] c_cap       = OCC_W'(CAPACITY);
  localparam logic [c_tmr_w-1:0] c_move_load = c_tmr_w'(MOVE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_pass_load = c_tmr_w'(PASS_TIMEOUT - 1);

  state_t           r_state;
  logic             r_entry_grant;
  logic             r_exit_grant;
  logic             r_gate_open;
  logic             r_entry_deny;
  logic             r_timeout_err;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] r_spaces;
  logic             r_full;
  logic             r_prefer_exit;  // direction to favour on contention
  logic             r_deny_armed;   // cleared by a deny until entry_req drops

  logic               w_entry_ok;
  logic               w_exit_ok;
  logic               w_pick_exit;
  logic               w_tmr_load;
  logic [c_tmr_w-1:0] w_tmr_value;
  logic               w_tmr_done;
  logic [OCC_W-1:0]   w_occ_next;

  assign w_entry_ok  = gate.entry_req && (r_occ < c_cap);
  assign w_exit_ok   = gate.exit_req && (r_occ != '0);
  assign w_pick_exit = w_exit_ok && (!w_entry_ok || r_prefer_exit);

  // Occupancy after a successful pass, saturating at both ends
  always_comb begin
    w_occ_next = r_occ;
    if (r_entry_grant) begin
      if (r_occ != c_cap) w_occ_next = r_occ + OCC_W'(1);
    end else if (r_occ != '0) begin
      w_occ_next = r_occ - OCC_W'(1);
    end
  end

  // Reload the phase timer on every transition into a timed state
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = c_move_load;
    case (r_state)
      ST_IDLE:    w_tmr_load = w_entry_ok || w_exit_ok;
      ST_OPENING: begin
        w_tmr_load  = w_tmr_done;
        w_tmr_value = c_pass_load;
      end
      ST_PASS:    w_tmr_load = gate.car_passed || w_tmr_done;
      default:    w_tmr_load = 1'b0;
    endcase
  end

  parking_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .done       (w_tmr_done)
  );

  // Gate controller: sequencing, grants, pulses and lot counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_entry_grant <= 1'b0;
      r_exit_grant  <= 1'b0;
      r_gate_open   <= 1'b0;
      r_entry_deny  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_occ         <= '0;
      r_spaces      <= c_cap;
      r_full        <= 1'b0;
      r_prefer_exit <= 1'b1;
      r_deny_armed  <= 1'b1;
    end else begin
      r_entry_deny  <= 1'b0;
      r_timeout_err <= 1'b0;
      if (!gate.entry_req) r_deny_armed <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (gate.entry_req && (r_occ == c_cap) && r_deny_armed) begin
            r_entry_deny <= 1'b1;
            r_deny_armed <= 1'b0;
          end
          if (w_entry_ok || w_exit_ok) begin
            r_state       <= ST_OPENING;
            r_gate_open   <= 1'b1;
            r_entry_grant <= !w_pick_exit;
            r_exit_grant  <= w_pick_exit;
            r_prefer_exit <= !w_pick_exit;
          end
        end

        ST_OPENING: begin
          if (w_tmr_done) r_state <= ST_PASS;
        end

        ST_PASS: begin
          // A pass on the last timeout cycle wins over the timeout
          if (gate.car_passed) begin
            r_state     <= ST_CLOSING;
            r_gate_open <= 1'b0;
            r_occ       <= w_occ_next;
            r_spaces    <= c_cap - w_occ_next;
            r_full      <= (w_occ_next == c_cap);
          end else if (w_tmr_done) begin
            r_state       <= ST_CLOSING;
            r_gate_open   <= 1'b0;
            r_timeout_err <= 1'b1;
          end
        end

        ST_CLOSING: begin
          if (w_tmr_done) begin
            r_state       <= ST_IDLE;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gate.entry_grant  = r_entry_grant;
  assign gate.exit_grant   = r_exit_grant;
  assign gate.gate_open    = r_gate_open;
  assign gate.entry_deny   = r_entry_deny;
  assign gate.timeout_err  = r_timeout_err;
  assign gate.occupancy    = r_occ;
  assign gate.spaces_left  = r_spaces;
  assign gate.parking_full = r_full;

endmodule : parking_gate_arbiter

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Brief    : Self-checking bench for parking_gate_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_arbiter;
  import parking_pkg::*;

  localparam int CAP  = 5;
  localparam int MOVE = 4;
  localparam int PT   = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parking_gate_arbiter_if bif();

  parking_gate_arbiter #(
    .CAPACITY     (CAP),
    .MOVE_CYCLES  (MOVE),
    .PASS_TIMEOUT (PT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gate  (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int to_seen = 0;

  // Reference model: a service is a timeline measured in clocks since grant.
  // Gate opens for MOVE clocks, waits up to PT clocks for the car, closes for MOVE.
  int m_occ;
  bit m_busy, m_dir_exit, m_prefer_exit, m_armed, m_deny, m_to;
  int m_age, m_close;

  function automatic void model_reset();
    m_occ = 0; m_busy = 0; m_dir_exit = 0; m_prefer_exit = 1; m_armed = 1;
    m_deny = 0; m_to = 0; m_age = 0; m_close = -1;
  endfunction

  function automatic void model_step(bit er, bit xr, bit cp);
    bit e_ok, x_ok, take_exit;
    m_deny = 0; m_to = 0;
    if (!m_busy) begin
      e_ok = er && (m_occ < CAP);
      x_ok = xr && (m_occ > 0);
      if (er && m_occ == CAP && m_armed) begin m_deny = 1; m_armed = 0; end
      if (e_ok || x_ok) begin
        take_exit = x_ok && (!e_ok || m_prefer_exit);
        m_busy = 1; m_dir_exit = take_exit; m_age = 0; m_close = -1;
        m_prefer_exit = !take_exit;
      end
    end else begin
      if (m_close < 0 && m_age >= MOVE) begin
        if (cp) begin
          m_occ = m_dir_exit ? m_occ - 1 : m_occ + 1;
          m_close = m_age + 1;
        end else if (m_age == MOVE + PT - 1) begin
          m_to = 1; m_close = m_age + 1;
        end
      end
      if (m_close >= 0 && m_age == m_close + MOVE - 1) m_busy = 0;
      else m_age++;
    end
    if (!er) m_armed = 1;
  endfunction

  function automatic logic [13:0] pack(bit eg, bit xg, bit go, bit dn, bit to, int occ);
    return {eg, xg, go, dn, to, (occ == CAP), 4'(occ), 4'(CAP - occ)};
  endfunction

  function automatic logic [13:0] model_vec();
    return pack(m_busy && !m_dir_exit, m_busy && m_dir_exit, m_busy && m_close < 0,
                m_deny, m_to, m_occ);
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bif.entry_grant, bif.exit_grant, bif.gate_open, bif.entry_deny,
            bif.timeout_err, bif.parking_full, bif.occupancy, bif.spaces_left};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b {eg,xg,go,deny,to,full,occ,spaces} (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, step the model at posedge, compare at next negedge
  task automatic cycle(input bit er, input bit xr, input bit cp);
    bif.entry_req  = er;
    bif.exit_req   = xr;
    bif.car_passed = cp;
    @(posedge clk);
    if (reset) model_step(er, xr, cp);
    else model_reset();
    @(negedge clk);
    if (reset) begin
      check_vec("model", dut_vec(), model_vec());
      if (bif.timeout_err) to_seen++;
    end
  endtask

  // Full service: request until granted, pass at the given age (-1: never)
  task automatic serve(input bit er, input bit xr, input bit hold, input int pass_age,
                       output bit granted_exit);
    int n = 0;
    granted_exit = 0;
    while (!m_busy && n < 20) begin cycle(er, xr, 0); n++; end
    if (!m_busy) begin
      check("serve_grant_timeout", 0, 1);
      return;
    end
    granted_exit = bif.exit_grant;
    while (m_busy && m_age < pass_age) cycle(hold && er, hold && xr, 0);
    if (m_busy && pass_age >= 0) cycle(hold && er, hold && xr, 1);
    n = 0;
    while (m_busy && n < 200) begin cycle(hold && er, hold && xr, 0); n++; end
  endtask

  typedef struct {
    bit          er;
    bit          xr;
    bit          cp;
    logic [13:0] exp;
  } vec_t;

  function automatic vec_t mk(bit er, bit xr, bit cp, bit eg, bit go, int occ);
    vec_t v;
    v.er = er; v.xr = xr; v.cp = cp;
    v.exp = pack(eg, 1'b0, go, 1'b0, 1'b0, occ);
    return v;
  endfunction

  initial begin
    vec_t tbl[12];
    bit   gx;
    bit   got;
    int   k, d_cnt, g_cnt, t0;
    bit   er, xr;

    // Single entry with a pass on the first PASS cycle, then an ignored pulse
    tbl[0]  = mk(1, 0, 0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 1);

    bif.entry_req = 0; bif.exit_req = 0; bif.car_passed = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_vec("reset_values", dut_vec(), pack(0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // Exit request on an empty lot is ignored
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0);
      check("empty_exit_grant", int'(bif.exit_grant), 0);
      check("empty_exit_gate", int'(bif.gate_open), 0);
    end
    cycle(0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].er, tbl[i].xr, tbl[i].cp);
      check_vec($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
    end

    // Fill the lot
    for (int i = 0; i < 4; i++) serve(1, 0, 0, MOVE, gx);
    check("full_flag", int'(bif.parking_full), 1);
    check("full_occ", int'(bif.occupancy), CAP);
    check("full_spaces", int'(bif.spaces_left), 0);

    // Held entry request on a full lot: one deny, no grant, re-arms after drop
    d_cnt = 0; g_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0);
      d_cnt += int'(bif.entry_deny);
      g_cnt += int'(bif.entry_grant);
    end
    check("deny_pulses", d_cnt, 1);
    check("deny_no_grant", g_cnt, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("deny_rearm", int'(bif.entry_deny), 1);
    cycle(0, 0, 0);

    serve(0, 1, 0, MOVE, gx);
    check("exit_granted", int'(gx), 1);
    check("exit_occ", int'(bif.occupancy), CAP - 1);

    // Timeout: no car during PASS
    k = 0;
    while (!m_busy && k < 20) begin cycle(1, 0, 0); k++; end
    while (m_busy && m_age < MOVE) cycle(0, 0, 0);
    got = 0; k = 0;
    for (int i = 1; i <= PT + 8 && !got; i++) begin
      cycle(0, 0, 0);
      if (bif.timeout_err) begin got = 1; k = i; end
    end
    check("timeout_latency", k, PT);
    check("timeout_occ", int'(bif.occupancy), CAP - 1);
    got = 0; k = 0;
    for (int i = 1; i <= MOVE + 4 && !got; i++) begin
      cycle(0, 0, 0);
      if (!bif.entry_grant) begin got = 1; k = i; end
    end
    check("timeout_close_len", k, MOVE);

    // Pass on the final timeout cycle counts as a pass
    t0 = to_seen;
    serve(1, 0, 0, MOVE + PT - 1, gx);
    check("late_pass_no_timeout", to_seen - t0, 0);
    check("late_pass_occ", int'(bif.occupancy), CAP);

    // Reset asserted mid-PASS of an entry
    serve(0, 1, 0, MOVE, gx);
    k = 0;
    while (!m_busy && k < 20) begin cycle(1, 0, 0); k++; end
    while (m_busy && m_age < MOVE + 2) cycle(0, 0, 0);
    #2 reset = 1'b0;
    model_reset();
    #1 check_vec("reset_async", dut_vec(), pack(0, 0, 0, 0, 0, 0));
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    reset = 1'b1;
    cycle(0, 0, 0);
    check("reset_occ", int'(bif.occupancy), 0);

    // Contention: exit first, then entry
    serve(1, 0, 0, MOVE, gx);
    serve(1, 0, 0, MOVE, gx);
    serve(1, 1, 1, MOVE, gx);
    check("rr_first_exit", int'(gx), 1);
    serve(1, 1, 1, MOVE, gx);
    check("rr_second_entry", int'(gx), 0);
    check("rr_occ", int'(bif.occupancy), 2);

    // Randomized traffic against the model
    er = 0; xr = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) er = !er;
      if ($urandom_range(0, 5) == 0) xr = !xr;
      cycle(er, xr, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_parking_gate_arbiter

`default_nettype wire
